// File: rtl/board_fill_tracker.sv
// Score 4 board state keeper: validates piece drops, stacks them into columns,
// and publishes per-column/board fullness and move count from registered state.
module board_fill_tracker #(
    parameter int COLS = 7,
    parameter int ROWS = 6,
    localparam int CW = $clog2(COLS),
    localparam int RW = $clog2(ROWS + 1),
    localparam int MW = $clog2(COLS * ROWS + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clear_i,
    input  logic                           drop_valid_i,
    input  logic [CW-1:0]                  drop_col_i,
    input  logic [1:0]                     drop_player_i,
    output logic                           drop_ack_o,
    output logic                           drop_err_o,
    output logic [1:0]                     err_code_o,
    output logic [RW-1:0]                  drop_row_o,
    output logic [COLS-1:0][ROWS-1:0][1:0] panel_o,
    output logic [COLS-1:0][RW-1:0]        heights_o,
    output logic [COLS-1:0]                col_full_o,
    output logic                           full_o,
    output logic [MW-1:0]                  move_count_o
);

    localparam logic [CW:0]   COLS_LIM = (CW + 1)'(COLS);
    localparam logic [RW-1:0] ROWS_H   = RW'(ROWS);

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_COL    = 2'b01;
    localparam logic [1:0] ERR_PLAYER = 2'b10;
    localparam logic [1:0] ERR_FULL   = 2'b11;

    logic [COLS-1:0][ROWS-1:0][1:0] panel_q, panel_d;
    logic [COLS-1:0][RW-1:0]        heights_q, heights_d;
    logic [MW-1:0]                  move_count_q, move_count_d;
    logic                           ack_q, ack_d;
    logic                           err_q, err_d;
    logic [1:0]                     code_q, code_d;
    logic [RW-1:0]                  row_q, row_d;

    logic [COLS-1:0] col_full;
    logic            sel_full;
    logic [RW-1:0]   sel_height;

    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            col_full[c] = (heights_q[c] == ROWS_H);
        end
    end

    always_comb begin
        panel_d      = panel_q;
        heights_d    = heights_q;
        move_count_d = move_count_q;
        ack_d        = 1'b0;
        err_d        = 1'b0;
        code_d       = ERR_NONE;
        row_d        = row_q;
        sel_full     = 1'b0;
        sel_height   = '0;

        for (int c = 0; c < COLS; c++) begin
            if (drop_col_i == CW'(c)) begin
                sel_full   = col_full[c];
                sel_height = heights_q[c];
            end
        end

        // A clear discards any same-cycle drop without a response pulse.
        if (clear_i) begin
            panel_d      = '0;
            heights_d    = '0;
            move_count_d = '0;
        end else if (drop_valid_i) begin
            if ({1'b0, drop_col_i} >= COLS_LIM) begin
                err_d  = 1'b1;
                code_d = ERR_COL;
            end else if (drop_player_i != 2'b01 && drop_player_i != 2'b10) begin
                err_d  = 1'b1;
                code_d = ERR_PLAYER;
            end else if (sel_full) begin
                err_d  = 1'b1;
                code_d = ERR_FULL;
            end else begin
                ack_d        = 1'b1;
                row_d        = sel_height;
                move_count_d = move_count_q + MW'(1);
                for (int c = 0; c < COLS; c++) begin
                    if (drop_col_i == CW'(c)) begin
                        heights_d[c] = heights_q[c] + RW'(1);
                        for (int r = 0; r < ROWS; r++) begin
                            if (heights_q[c] == RW'(r)) begin
                                panel_d[c][r] = drop_player_i;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            panel_q      <= '0;
            heights_q    <= '0;
            move_count_q <= '0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            code_q       <= ERR_NONE;
            row_q        <= '0;
        end else begin
            panel_q      <= panel_d;
            heights_q    <= heights_d;
            move_count_q <= move_count_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            code_q       <= code_d;
            row_q        <= row_d;
        end
    end

    assign panel_o      = panel_q;
    assign heights_o    = heights_q;
    assign col_full_o   = col_full;
    assign full_o       = &col_full;
    assign move_count_o = move_count_q;
    assign drop_ack_o   = ack_q;
    assign drop_err_o   = err_q;
    assign err_code_o   = code_q;
    assign drop_row_o   = row_q;

endmodule

// File: tb/tb_board_fill_tracker.sv
// Self-checking bench for board_fill_tracker: 7x6 instance against a behavioural
// model (table, corner sequences, random), plus a 4x3 instance fill check.
module tb_board_fill_tracker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- 7x6 instance ----------------
    logic              a_rst, a_clear, a_valid;
    logic [2:0]        a_col;
    logic [1:0]        a_pl;
    logic              a_ack, a_err, a_full;
    logic [1:0]        a_code;
    logic [2:0]        a_row;
    logic [6:0][5:0][1:0] a_panel;
    logic [6:0][2:0]   a_heights;
    logic [6:0]        a_colfull;
    logic [5:0]        a_moves;

    board_fill_tracker #(.COLS(7), .ROWS(6)) dut_a (
        .clk_i(clk), .rst_i(a_rst), .clear_i(a_clear), .drop_valid_i(a_valid),
        .drop_col_i(a_col), .drop_player_i(a_pl),
        .drop_ack_o(a_ack), .drop_err_o(a_err), .err_code_o(a_code), .drop_row_o(a_row),
        .panel_o(a_panel), .heights_o(a_heights), .col_full_o(a_colfull),
        .full_o(a_full), .move_count_o(a_moves)
    );

    // ---------------- 4x3 instance ----------------
    logic              b_rst, b_clear, b_valid;
    logic [1:0]        b_col;
    logic [1:0]        b_pl;
    logic              b_ack, b_err, b_full;
    logic [1:0]        b_code;
    logic [1:0]        b_row;
    logic [3:0][2:0][1:0] b_panel;
    logic [3:0][1:0]   b_heights;
    logic [3:0]        b_colfull;
    logic [3:0]        b_moves;

    board_fill_tracker #(.COLS(4), .ROWS(3)) dut_b (
        .clk_i(clk), .rst_i(b_rst), .clear_i(b_clear), .drop_valid_i(b_valid),
        .drop_col_i(b_col), .drop_player_i(b_pl),
        .drop_ack_o(b_ack), .drop_err_o(b_err), .err_code_o(b_code), .drop_row_o(b_row),
        .panel_o(b_panel), .heights_o(b_heights), .col_full_o(b_colfull),
        .full_o(b_full), .move_count_o(b_moves)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the 7x6 board: plain counts and a cell grid.
    int m_h [7];
    int m_cell [7][6];
    int m_moves;
    bit e_ack, e_err;
    int e_code, e_row;

    task automatic model_clear();
        for (int c = 0; c < 7; c++) begin
            m_h[c] = 0;
            for (int r = 0; r < 6; r++) m_cell[c][r] = 0;
        end
        m_moves = 0;
    endtask

    task automatic model_step(input bit r, input bit cl, input bit v, input int col, input int pl);
        e_ack = 0; e_err = 0; e_code = 0;
        if (r) begin
            model_clear();
            e_row = 0;
        end else if (cl) begin
            model_clear();
        end else if (v) begin
            if (col >= 7) begin e_err = 1; e_code = 1; end
            else if (pl != 1 && pl != 2) begin e_err = 1; e_code = 2; end
            else if (m_h[col] == 6) begin e_err = 1; e_code = 3; end
            else begin
                m_cell[col][m_h[col]] = pl;
                e_row = m_h[col];
                m_h[col] = m_h[col] + 1;
                m_moves = m_moves + 1;
                e_ack = 1;
            end
        end
    endtask

    task automatic check_all();
        logic [6:0][5:0][1:0] ep;
        logic [6:0][2:0]      eh;
        logic [6:0]           ef;
        for (int c = 0; c < 7; c++) begin
            eh[c] = 3'(m_h[c]);
            ef[c] = (m_h[c] == 6);
            for (int r = 0; r < 6; r++) ep[c][r] = 2'(m_cell[c][r]);
        end
        chk("ack", 128'(a_ack), 128'(e_ack));
        chk("err", 128'(a_err), 128'(e_err));
        chk("err_code", 128'(a_code), 128'(e_code));
        chk("drop_row", 128'(a_row), 128'(e_row));
        chk("move_count", 128'(a_moves), 128'(m_moves));
        chk("heights", 128'(a_heights), 128'(eh));
        chk("col_full", 128'(a_colfull), 128'(ef));
        chk("full", 128'(a_full), 128'(&ef));
        chk("panel", 128'(a_panel), 128'(ep));
    endtask

    task automatic apply_a(input bit r, input bit cl, input bit v, input int col, input int pl);
        a_rst = r; a_clear = cl; a_valid = v; a_col = 3'(col); a_pl = 2'(pl);
        @(posedge clk); #1;
        model_step(r, cl, v, col, pl);
        a_rst = 0; a_clear = 0; a_valid = 0;
        check_all();
    endtask

    task automatic apply_b(input bit v, input int col, input int pl);
        b_valid = v; b_col = 2'(col); b_pl = 2'(pl);
        @(posedge clk); #1;
        b_valid = 0;
    endtask

    typedef struct {
        bit v;
        int col;
        int pl;
        bit x_ack;
        bit x_err;
        int x_code;
        int x_row;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(bit v, int col, int pl, bit xa, bit xe, int xc, int xr);
        vec_t t;
        t.v = v; t.col = col; t.pl = pl;
        t.x_ack = xa; t.x_err = xe; t.x_code = xc; t.x_row = xr;
        return t;
    endfunction

    initial begin
        a_rst = 1; a_clear = 0; a_valid = 0; a_col = 0; a_pl = 0;
        b_rst = 1; b_clear = 0; b_valid = 0; b_col = 0; b_pl = 0;
        e_row = 0;
        model_clear();

        tbl[0]  = mk(1, 3, 1, 1, 0, 0, 0);
        tbl[1]  = mk(1, 0, 1, 1, 0, 0, 0);
        tbl[2]  = mk(1, 0, 2, 1, 0, 0, 1);
        tbl[3]  = mk(1, 0, 1, 1, 0, 0, 2);
        tbl[4]  = mk(1, 0, 2, 1, 0, 0, 3);
        tbl[5]  = mk(1, 0, 1, 1, 0, 0, 4);
        tbl[6]  = mk(1, 0, 2, 1, 0, 0, 5);
        tbl[7]  = mk(1, 0, 1, 0, 1, 3, 5);
        tbl[8]  = mk(1, 7, 1, 0, 1, 1, 5);
        tbl[9]  = mk(1, 1, 0, 0, 1, 2, 5);
        tbl[10] = mk(1, 1, 3, 0, 1, 2, 5);
        tbl[11] = mk(1, 7, 0, 0, 1, 1, 5);
        tbl[12] = mk(0, 2, 1, 0, 0, 0, 5);
        tbl[13] = mk(1, 2, 2, 1, 0, 0, 0);

        // Reset values
        apply_a(1, 0, 0, 0, 0);
        apply_a(1, 0, 1, 3, 1);

        // Table vectors: single drop, column fill, error priority, drop_row hold
        for (int i = 0; i < 14; i++) begin
            apply_a(0, 0, tbl[i].v, tbl[i].col, tbl[i].pl);
            chk($sformatf("tbl%0d_ack", i), 128'(a_ack), 128'(tbl[i].x_ack));
            chk($sformatf("tbl%0d_err", i), 128'(a_err), 128'(tbl[i].x_err));
            chk($sformatf("tbl%0d_code", i), 128'(a_code), 128'(tbl[i].x_code));
            chk($sformatf("tbl%0d_row", i), 128'(a_row), 128'(tbl[i].x_row));
            if (i == 0) chk("first_panel_3_0", 128'(a_panel[3][0]), 128'(2'b01));
            if (i == 7) chk("col0_full_bits", 128'(a_colfull), 128'(7'b0000001));
        end

        // Clear with a same-cycle drop on a partly filled board
        apply_a(0, 1, 1, 4, 1);
        chk("clear_moves", 128'(a_moves), 128'(0));
        apply_a(0, 0, 0, 0, 0);

        // Fill every cell; full rises with the 42nd ack
        for (int c = 0; c < 7; c++) begin
            for (int r = 0; r < 6; r++) begin
                apply_a(0, 0, 1, c, ((c + r) % 2) + 1);
                chk("fill_full", 128'(a_full), 128'(c == 6 && r == 5));
            end
        end
        chk("fill_moves", 128'(a_moves), 128'(42));
        for (int c = 0; c < 7; c++) begin
            apply_a(0, 0, 1, c, 2);
            chk("full_reject_code", 128'(a_code), 128'(3));
        end

        // Reset mid-sequence with a pending drop
        apply_a(1, 0, 0, 0, 0);
        apply_a(0, 0, 1, 5, 1);
        apply_a(0, 0, 1, 5, 2);
        apply_a(1, 0, 1, 5, 1);
        chk("rst_mid_row", 128'(a_row), 128'(0));
        apply_a(0, 0, 0, 0, 0);

        // Random stimulus against the model
        for (int i = 0; i < 600; i++) begin
            apply_a($urandom_range(0, 99) == 0, $urandom_range(0, 59) == 0,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3));
        end

        // 4x3 instance: full after 12 accepts
        b_rst = 1;
        @(posedge clk); #1;
        b_rst = 0;
        chk("b_reset_full", 128'(b_full), 128'(0));
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 3; r++) begin
                apply_b(1, c, (r % 2) + 1);
                chk("b_ack", 128'(b_ack), 128'(1));
                chk("b_row", 128'(b_row), 128'(r));
                chk("b_full", 128'(b_full), 128'(c == 3 && r == 2));
            end
        end
        chk("b_moves", 128'(b_moves), 128'(12));
        chk("b_colfull", 128'(b_colfull), 128'(4'b1111));
        apply_b(1, 1, 1);
        chk("b_full_err", 128'(b_err), 128'(1));
        chk("b_full_code", 128'(b_code), 128'(3));
        apply_b(1, 2, 0);
        chk("b_player_code", 128'(b_code), 128'(2));
        apply_b(0, 0, 0);
        chk("b_code_idle", 128'(b_code), 128'(0));
        chk("b_moves_hold", 128'(b_moves), 128'(12));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
